// File: rtl/nsc8_control_sequencer.sv
// nsc8_control_sequencer
// ----------------------
// Microcoded control sequencer for the NSC-8 8-bit CPU. A 3-bit step
// counter walks each instruction through fetch (T0-T1) and execute
// (T2-T4). A halted latch freezes the machine after HLT until reset.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   opcode                instruction opcode from the IR (used in T2-T4)
//   carry_flag, zero_flag registered ALU flags for JC / JZ
//   pc_increment, output_pc, load_pc          program counter controls
//   load_mar                                  memory address register load
//   output_ram, load_ram                      RAM controls
//   load_ir, output_ir                        instruction register controls
//   load_a, output_a, load_b                  A / B register controls
//   output_alu, subtract_enable               ALU controls
//   load_flags, load_out                      flag / output register loads
//   halt                                      high while halted
//   step                                      current T-state (debug)
module nsc8_control_sequencer #(
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                pc_increment,
    output logic                output_pc,
    output logic                load_pc,
    output logic                load_mar,
    output logic                output_ram,
    output logic                load_ram,
    output logic                load_ir,
    output logic                output_ir,
    output logic                load_a,
    output logic                output_a,
    output logic                load_b,
    output logic                output_alu,
    output logic                subtract_enable,
    output logic                load_flags,
    output logic                load_out,
    output logic                halt,
    output logic [2:0]          step
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0111);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b1000);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

    logic [2:0] step_q;
    logic       halted;
    logic       last_step;
    logic       is_alu_op;
    logic       is_mem_op;

    assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_STA);

    // Final step of the current instruction: the counter returns to T0
    // after it. Codes above T4 are unreachable but are folded back to T0
    // so the counter can never wander.
    always_comb begin
        last_step = 1'b0;
        case (step_q)
            T0, T1:  last_step = 1'b0;
            T2:      last_step = !(is_alu_op || is_mem_op);
            T3:      last_step = !is_alu_op;
            default: last_step = 1'b1;
        endcase
    end

    // Step counter and halt latch. HLT latches on the edge ending its T2;
    // once halted the counter sits at T0 until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= T0;
            halted <= 1'b0;
        end else if (halted) begin
            step_q <= T0;
        end else if (last_step) begin
            step_q <= T0;
            if ((step_q == T2) && (opcode == OP_HLT)) begin
                halted <= 1'b1;
            end
        end else begin
            step_q <= step_q + 3'd1;
        end
    end

    // Control decode. Everything is gated by rst_n so the bus is quiet
    // during reset even though step reads T0 there.
    always_comb begin
        pc_increment    = 1'b0;
        output_pc       = 1'b0;
        load_pc         = 1'b0;
        load_mar        = 1'b0;
        output_ram      = 1'b0;
        load_ram        = 1'b0;
        load_ir         = 1'b0;
        output_ir       = 1'b0;
        load_a          = 1'b0;
        output_a        = 1'b0;
        load_b          = 1'b0;
        output_alu      = 1'b0;
        subtract_enable = 1'b0;
        load_flags      = 1'b0;
        load_out        = 1'b0;
        if (rst_n && !halted) begin
            case (step_q)
                T0: begin
                    output_pc = 1'b1;
                    load_mar  = 1'b1;
                end
                T1: begin
                    output_ram   = 1'b1;
                    load_ir      = 1'b1;
                    pc_increment = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            output_ir = 1'b1;
                            load_mar  = 1'b1;
                        end
                        OP_LDI: begin
                            output_ir = 1'b1;
                            load_a    = 1'b1;
                        end
                        OP_JMP: begin
                            output_ir = 1'b1;
                            load_pc   = 1'b1;
                        end
                        OP_JC: begin
                            output_ir = carry_flag;
                            load_pc   = carry_flag;
                        end
                        OP_JZ: begin
                            output_ir = zero_flag;
                            load_pc   = zero_flag;
                        end
                        OP_OUT: begin
                            output_a = 1'b1;
                            load_out = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            output_ram = 1'b1;
                            load_a     = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            output_ram = 1'b1;
                            load_b     = 1'b1;
                        end
                        OP_STA: begin
                            output_a = 1'b1;
                            load_ram = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (is_alu_op) begin
                        output_alu      = 1'b1;
                        load_a          = 1'b1;
                        load_flags      = 1'b1;
                        subtract_enable = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt = halted && rst_n;
    assign step = step_q;

endmodule

// File: tb/tb_nsc8_control_sequencer.sv
// tb_nsc8_control_sequencer
// -------------------------
// Self-checking bench for nsc8_control_sequencer. A reference model turns
// each instruction into the list of control words it should produce, one
// per cycle; the bench drives randomized instruction streams and flags and
// compares every cycle, plus reset, halt and abort scenarios.
//
// Ports: none (top-level bench).
module tb_nsc8_control_sequencer;

    localparam logic [15:0] M_PC_INC   = 16'h8000;
    localparam logic [15:0] M_OUT_PC   = 16'h4000;
    localparam logic [15:0] M_LOAD_PC  = 16'h2000;
    localparam logic [15:0] M_LOAD_MAR = 16'h1000;
    localparam logic [15:0] M_OUT_RAM  = 16'h0800;
    localparam logic [15:0] M_LOAD_RAM = 16'h0400;
    localparam logic [15:0] M_LOAD_IR  = 16'h0200;
    localparam logic [15:0] M_OUT_IR   = 16'h0100;
    localparam logic [15:0] M_LOAD_A   = 16'h0080;
    localparam logic [15:0] M_OUT_A    = 16'h0040;
    localparam logic [15:0] M_LOAD_B   = 16'h0020;
    localparam logic [15:0] M_OUT_ALU  = 16'h0010;
    localparam logic [15:0] M_SUB_EN   = 16'h0008;
    localparam logic [15:0] M_LOAD_FLG = 16'h0004;
    localparam logic [15:0] M_LOAD_OUT = 16'h0002;
    localparam logic [15:0] M_HALT     = 16'h0001;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic       pc_increment, output_pc, load_pc, load_mar;
    logic       output_ram, load_ram, load_ir, output_ir;
    logic       load_a, output_a, load_b, output_alu;
    logic       subtract_enable, load_flags, load_out, halt;
    logic [2:0] step;
    logic [15:0] ctrl;
    int         drivers;

    int check_count = 0;
    int fail_count  = 0;
    logic [15:0] exp_q[$];

    nsc8_control_sequencer #(.OPCODE_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .carry_flag      (carry_flag),
        .zero_flag       (zero_flag),
        .pc_increment    (pc_increment),
        .output_pc       (output_pc),
        .load_pc         (load_pc),
        .load_mar        (load_mar),
        .output_ram      (output_ram),
        .load_ram        (load_ram),
        .load_ir         (load_ir),
        .output_ir       (output_ir),
        .load_a          (load_a),
        .output_a        (output_a),
        .load_b          (load_b),
        .output_alu      (output_alu),
        .subtract_enable (subtract_enable),
        .load_flags      (load_flags),
        .load_out        (load_out),
        .halt            (halt),
        .step            (step)
    );

    assign ctrl = {pc_increment, output_pc, load_pc, load_mar,
                   output_ram, load_ram, load_ir, output_ir,
                   load_a, output_a, load_b, output_alu,
                   subtract_enable, load_flags, load_out, halt};
    assign drivers = int'(output_pc) + int'(output_ram) + int'(output_ir)
                   + int'(output_a) + int'(output_alu);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log misses.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic c,
                                 input logic z);
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
    endtask

    // Reference model: the per-cycle control words of one instruction,
    // fetch included. Its length is the instruction length in cycles.
    task automatic buildModel(input logic [3:0] op, input logic c,
                              input logic z);
        exp_q = {};
        exp_q.push_back(M_OUT_PC | M_LOAD_MAR);
        exp_q.push_back(M_OUT_RAM | M_LOAD_IR | M_PC_INC);
        case (op)
            4'd1: begin
                exp_q.push_back(M_OUT_IR | M_LOAD_MAR);
                exp_q.push_back(M_OUT_RAM | M_LOAD_A);
            end
            4'd2, 4'd3: begin
                exp_q.push_back(M_OUT_IR | M_LOAD_MAR);
                exp_q.push_back(M_OUT_RAM | M_LOAD_B);
                exp_q.push_back(M_OUT_ALU | M_LOAD_A | M_LOAD_FLG |
                                ((op == 4'd3) ? M_SUB_EN : 16'h0000));
            end
            4'd4: begin
                exp_q.push_back(M_OUT_IR | M_LOAD_MAR);
                exp_q.push_back(M_OUT_A | M_LOAD_RAM);
            end
            4'd5:  exp_q.push_back(M_OUT_IR | M_LOAD_A);
            4'd6:  exp_q.push_back(M_OUT_IR | M_LOAD_PC);
            4'd7:  exp_q.push_back(c ? (M_OUT_IR | M_LOAD_PC) : 16'h0000);
            4'd8:  exp_q.push_back(z ? (M_OUT_IR | M_LOAD_PC) : 16'h0000);
            4'd14: exp_q.push_back(M_OUT_A | M_LOAD_OUT);
            default: exp_q.push_back(16'h0000);
        endcase
    endtask

    // Runs one instruction from its T0 cycle. Entry and exit are both
    // 1 time unit after a rising edge. Opcode is garbage during fetch.
    task automatic runInstruction(input logic [3:0] op, input logic c,
                                  input logic z);
        buildModel(op, c, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < 2) applyStimulus(4'($urandom_range(0, 15)), c, z);
            else       applyStimulus(op, c, z);
            #1;
            checkOutput($sformatf("ctrl op%0d T%0d", op, i), 32'(ctrl),
                        32'(exp_q[i]));
            checkOutput($sformatf("step op%0d T%0d", op, i), 32'(step),
                        32'(i));
            checkOutput("bus", (drivers <= 1) ? 32'd1 : 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] op;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("reset ctrl", 32'(ctrl), 32'd0);
        checkOutput("reset step", 32'(step), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset held ctrl", 32'(ctrl), 32'd0);
        checkOutput("reset held step", 32'(step), 32'd0);
        rst_n = 1'b1;

        // Directed: ADD, SUB, conditional jumps both ways.
        runInstruction(4'd2, 1'b0, 1'b0);
        runInstruction(4'd3, 1'b1, 1'b1);
        runInstruction(4'd7, 1'b1, 1'b0);
        runInstruction(4'd7, 1'b0, 1'b1);
        runInstruction(4'd8, 1'b0, 1'b1);
        runInstruction(4'd8, 1'b1, 1'b0);

        // Sweep every non-halting opcode with all flag combinations.
        for (int o = 0; o < 15; o++) begin
            for (int f = 0; f < 4; f++) begin
                runInstruction(4'(o), f[0], f[1]);
            end
        end

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 14));
            runInstruction(op, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
        end

        // Abort ADD in T3 with an asynchronous reset between edges.
        applyStimulus(4'd2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort pre T3", 32'(ctrl), 32'(M_OUT_RAM | M_LOAD_B));
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort ctrl", 32'(ctrl), 32'd0);
        checkOutput("abort step", 32'(step), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort held step", 32'(step), 32'd0);
        rst_n = 1'b1;
        runInstruction(4'd1, 1'b0, 1'b0);
        runInstruction(4'd4, 1'b0, 1'b0);

        // Program LDI, OUT, HLT, then the machine must stay halted.
        runInstruction(4'd5, 1'b0, 1'b0);
        runInstruction(4'd14, 1'b0, 1'b0);
        runInstruction(4'd15, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            #1;
            checkOutput("halted ctrl", 32'(ctrl), 32'(M_HALT));
            checkOutput("halted step", 32'(step), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("halt cleared", 32'(halt), 32'd0);
        checkOutput("halt reset ctrl", 32'(ctrl), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runInstruction(4'd6, 1'b0, 1'b0);
        runInstruction(4'd9, 1'b1, 1'b1);
        #1;
        checkOutput("final step", 32'(step), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 check_count, fail_count);
        $finish;
    end

endmodule
